spi_slave: RTL
==============

# spi_slave

SPI mode-0 responder, MSB first, 8-bit frames, clocked entirely by the system clock. It is the far end of the link driven by our `spi_master`. It oversamples the external `sclk`/`ss`/`mosi` pins through 2-flop synchronizers and shifts out a byte supplied over a ready/valid port. Each received byte is presented as a one-cycle strobe.

## Interface
- `IDLE_BYTE`, default 8'h00: byte shifted out when no TX byte is queued at frame or byte start.
- `clk` input 1: system clock; must run at ≥ 8× the `sclk` frequency.
- `rst` input 1: asynchronous, active-high reset.
- `tx_data` input 8: next byte to transmit.
- `tx_valid` input 1: `tx_data` valid.
- `tx_ready` output 1: the 1-entry holding register is empty. A transfer occurs when `tx_valid && tx_ready`.
- `tx_underrun` output 1: one-cycle pulse when `IDLE_BYTE` is loaded because the holding register was empty.
- `rx_data` output 8: last complete received byte; holds until the next byte completes.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `sclk` input 1: SPI clock from the master; idles low.
- `mosi` input 1: master-out data.
- `ss` input 1: slave select, active low.
- `miso` output 1: slave-out data (registered).
- `miso_oe` output 1: tri-state enable for the pad; high while selected.

## Operation
- **Synchronization.** `sclk`, `ss` and `mosi` each pass through 2 flops. A third flop on `sclk` and on `ss` provides edge detection. All logic uses the synchronized versions only.
- **States.** Two states: IDLE and SHIFT.
  - IDLE → SHIFT on synced `ss` falling.
  - SHIFT → IDLE on synced `ss` rising, from any bit position.
- **Frame start** (entry to SHIFT):
  - Shift register loads from the holding register if full; otherwise loads `IDLE_BYTE` and pulses `tx_underrun`.
  - `miso` = shift[7].
  - Bit counter = 0; `miso_oe` = 1.
- **Rising `sclk` edge in SHIFT:** rx_shift ← {rx_shift[6:0], mosi_sync}; counter +1 (3-bit, wraps 7→0).
- **Rising edge that completes bit 7** (counter 7→0): `rx_data` ← {rx_shift[6:0], mosi_sync}; `rx_valid` pulses.
- **Falling `sclk` edge in SHIFT:**
  - If counter ≠ 0: shift ← {shift[6:0], 0}; `miso` ← new shift[7].
  - If counter = 0 (byte boundary): reload from holding or `IDLE_BYTE` as at frame start; `miso` ← new bit 7.
- **Holding register.**
  - Filled on handshake; emptied on a reload.
  - `tx_ready` = empty.
  - No bypass: if the holding register is empty in the reload cycle, an underrun occurs even if `tx_valid` is high that cycle. That `tx_valid` write is still accepted into the holding register.
- **`ss` rising mid-byte:**
  - Partial RX bits discarded; no `rx_valid`.
  - Partial TX byte discarded; the holding register is preserved.
  - Counter cleared; `miso_oe` ← 0; `miso` ← 0.
- **Edge handling in IDLE:** `sclk` edges are ignored. A `sclk` edge in the same cycle as the synced `ss` falling edge is ignored.

## Timing
- **Reset values:** `tx_ready`=1, `tx_underrun`=0, `rx_data`=8'h00, `rx_valid`=0, `miso`=0, `miso_oe`=0. State IDLE, holding register empty, counters 0.
- **Pin-to-detection:** a pin edge is detected 2–3 `clk` cycles after it occurs (synchronizer phase). Registered outputs update 1 cycle after detection:
  - `rx_valid` 3–4 cycles after the 8th `sclk` rising edge.
  - `miso` 3–4 cycles after `sclk` falling.
  - `miso_oe` 3–4 cycles after `ss` falling.
- **Master constraint:** the master must leave ≥ 4 `clk` cycles between `ss` falling and the first `sclk` rising edge. This guarantees the first bit is valid on `miso`.
- **`tx_ready` after reload:** deasserts the cycle after a handshake; reasserts the cycle after a reload.
- **Byte pipelining:** a byte queued before the falling edge following bit 7 is sent back-to-back with no gap.

## Test plan
1. **Single byte.** Reset, queue tx 8'hA5, master sends 8'h3C in one frame → master reads 8'hA5; `rx_data`=8'h3C with exactly one `rx_valid` pulse; `tx_ready` back to 1; `tx_underrun` never pulses.
2. **Back-to-back bytes.** Queue 8'h01, then 8'h02 after `tx_ready`; master sends 8'hF0, 8'h0F in one frame → master reads 01, 02; two `rx_valid` pulses with 8'hF0 then 8'h0F.
3. **Underrun.** Nothing queued, `IDLE_BYTE`=8'h00, master sends 8'h55 → master reads 8'h00; `tx_underrun` pulses once at frame start; `rx_data`=8'h55.
4. **Abort.** Queue 8'hC3, master clocks 4 bits then raises `ss` → no `rx_valid`; `miso_oe`=0. The next frame transmits the queued second byte, or `IDLE_BYTE` if none is queued; `rx_data` is unchanged until the next full byte.
5. **Async reset mid-frame.** Assert `rst` after 3 bits → all outputs at reset values immediately (same cycle); the next full frame completes correctly.
6. **Clock ratio and ignored edges.** Run `clk` = 8× `sclk` with randomized pin phase; toggle `sclk` while `ss` is high → no `rx_valid`, `miso_oe` stays 0, and no data corruption across 256 random bytes.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI responder bundle: transmit handshake, receive strobe and the four SPI pins.
// The slave modport is the responder's view; the master modport is the link partner and byte source/sink.
interface spi_slave_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sclk;
  logic       mosi;
  logic       ss;
  logic       miso;
  logic       miso_oe;

  modport slave (
    input  tx_data, tx_valid, sclk, mosi, ss,
    output tx_ready, tx_underrun, rx_data, rx_valid, miso, miso_oe
  );

  modport master (
    output tx_data, tx_valid, sclk, mosi, ss,
    input  tx_ready, tx_underrun, rx_data, rx_valid, miso, miso_oe
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8-bit frames, fully in the system clock domain.
// Pins are oversampled through 2-flop synchronizers; a 1-entry holding register feeds the transmit shifter.
module spi_slave #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  spi_slave_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic       hold_full;
  logic [7:0] hold_data;
  logic [6:0] tx_shift;
  logic [6:0] rx_shift;
  logic       miso;
  logic       miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic ss_p0, ss_p1, ss_p2;
  logic mosi_p0, mosi_p1;

  // Stage p0/p1: metastability filter; p2 keeps the previous synced value for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      ss_p0   <= 1'b1;
      ss_p1   <= 1'b1;
      ss_p2   <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= bus.sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      ss_p0   <= bus.ss;
      ss_p1   <= ss_p0;
      ss_p2   <= ss_p1;
      mosi_p0 <= bus.mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic       in_shift, frame_start, rise_shift, fall_shift, reload, accept;
  logic [7:0] load_byte;
  logic [7:0] rx_byte;

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign ss_fall   = ~ss_p1 & ss_p2;
  assign ss_rise   = ss_p1 & ~ss_p2;

  // Deselect wins over a coincident sclk edge, so a master releasing ss together
  // with its last sclk fall does not trigger a byte-boundary reload.
  assign in_shift    = (state == SHIFT);
  assign frame_start = ~in_shift & ss_fall;
  assign rise_shift  = in_shift & ~ss_rise & sclk_rise;
  assign fall_shift  = in_shift & ~ss_rise & sclk_fall;
  assign reload      = frame_start | (fall_shift & (bit_cnt == 3'd0));
  assign accept      = bus.tx_valid & ~hold_full;
  assign load_byte   = hold_full ? hold_data : IDLE_BYTE;
  assign rx_byte     = {rx_shift, mosi_p1};

  // Stage p3: datapath registers, no reset needed
  always_ff @(posedge clk) begin
    if (accept)
      hold_data <= bus.tx_data;
    if (reload)
      tx_shift <= load_byte[6:0];
    else if (fall_shift)
      tx_shift <= {tx_shift[5:0], 1'b0};
    if (rise_shift)
      rx_shift <= rx_byte[6:0];
  end

  // Stage p3: control FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      hold_full   <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= reload & ~hold_full;
      // A reload empties the holding register; a same-cycle write still lands in it
      hold_full   <= (hold_full & ~reload) | accept;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state   <= SHIFT;
            bit_cnt <= 3'd0;
            miso_oe <= 1'b1;
            miso    <= load_byte[7];
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
          end else begin
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
              end
            end
            if (sclk_fall) begin
              if (bit_cnt == 3'd0)
                miso <= load_byte[7];
              else
                miso <= tx_shift[6];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready    = ~hold_full;
  assign bus.tx_underrun = tx_underrun;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.miso        = miso;
  assign bus.miso_oe     = miso_oe;

endmodule
